adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one `adder_nbit` instance between two independent requesters, each with valid/ready handshakes.
- Round-robin arbiter plus a 3-state sequencer:
  - latches the granted operands;
  - runs one add;
  - holds the result on a response channel until it is consumed.
- Sits between the switch/LED front-end logic and the adder datapath, so two lab front-ends can time-share a single adder.

Parameters:
- BIT_WIDTH, 8, operand and sum width passed to the shared `adder_nbit`.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  BIT_WIDTH  requester 0 operand a
- req0_b  in  BIT_WIDTH  requester 0 operand b
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  BIT_WIDTH  registered sum
- rsp_cout  out  1  registered carry/overflow
- rsp_id  out  1  requester that owns the result (0/1)
- busy  out  1  high in ADD or HOLD
- err  out  1  sticky adder self-check error (see Optional Feature)

Behaviour:
- Reset:
  - The design has one clock.
  - Reset is synchronous and active-high: `rst` sampled high at a `clk` edge forces the reset state.
  - Reset state: state=IDLE; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, err=0; last_grant=1, so requester 0 wins the first tie.
- FSM states are IDLE, ADD and HOLD.
- IDLE:
  - req*_ready is combinational: high only for the granted requester, and only when that requester's valid is high.
  - Grant rule: if only one requester is valid, it wins. If both are valid, the winner is the requester that is not last_grant.
  - On a handshake, latch a, b and cin into operand registers, set id = winner and last_grant = winner, then go to ADD.
  - With no valid requester, stay in IDLE.
- ADD:
  - The latched operands drive the `adder_nbit` instance.
  - The sum and overflow are registered into rsp_sum/rsp_cout, rsp_id is set to id, rsp_valid is set to 1, and the FSM goes to HOLD.
  - Both req*_ready are low.
- HOLD:
  - rsp_valid stays 1, and rsp_sum, rsp_cout and rsp_id stay stable until rsp_ready=1.
  - On the handshake: rsp_valid goes to 0 at the next edge and the FSM goes to IDLE. rsp_sum, rsp_cout and rsp_id retain their values.
  - No new request is accepted in HOLD.
- Latency: request handshake at edge N → rsp_valid high after edge N+1, i.e. rsp_valid is visible in cycle N+1.
- Minimum occupancy per operation is 3 cycles: IDLE, ADD, HOLD.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(BIT_WIDTH+1).
  - Example: FF+01+0 gives cout=1, sum=00.
- Boundary conditions:
  - rsp_ready held high continuously: HOLD lasts exactly 1 cycle.
  - A requester dropping valid in IDLE without a handshake is legal; no grant occurs and last_grant is unchanged.
  - rst asserted in ADD or HOLD: the in-flight operation is dropped, no response is produced, and all reset values apply.
  - Requester inputs are ignored outside IDLE.

Optional Feature:
- Macro: ADDER_SELF_CHECK_EN.
- Defined:
  - In ADD, the `adder_nbit` result is compared against a behavioural reference a+b+cin of width BIT_WIDTH+1.
  - A mismatch sets err=1 at that edge.
  - err is sticky and is cleared only by rst.
- Undefined: err is tied to 0, the comparator is absent, and the port remains.

Decomposition:
- Package `adder_ctrl_pkg` holds:
  - `state_t` enum {IDLE, ADD, HOLD};
  - localparams NUM_REQ=2, REQ0=1'b0, REQ1=1'b1.
- Sub-module: the existing `adder_nbit` (BIT_WIDTH passed through), instantiated once.
- Arbitration and the FSM stay in this module; a separate arbiter sub-module is not warranted.

Test Plan:
- Reset then simultaneous request: both valid after rst, req0 3C+04+0 and req1 10+20+1 → req0_ready first; rsp sum=40, cout=0, id=0. Next grant goes to req1 → sum=31, id=1.
- Overflow: req1 FF+01+0 → rsp_sum=00, rsp_cout=1, rsp_id=1; rsp_valid first seen the cycle after the handshake.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid, sum and id stable, busy=1, req0/req1 ready both 0. After rsp_ready=1 for one cycle → IDLE.
- Fairness: both requesters valid continuously for 6 operations → rsp_id sequence 0,1,0,1,0,1.
- Reset mid-op: rst asserted in HOLD → next cycle rsp_valid=0, busy=0. With both valid afterwards, req0 wins.
- With ADDER_SELF_CHECK_EN: force a faulty adder output (e.g. bind/force sum bit0) during ADD → err=1 and it stays 1 until rst. Without the macro, err=0 throughout.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : adder_ctrl_pkg                                           |
// | Purpose   : Shared types and constants for the adder share arbiter.  |
// |             The sequencer state encoding lives here, together with   |
// |             the requester count and requester identifiers.           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package adder_ctrl_pkg;

   // Sequencer states: accept a request, run one add, present the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int   NUM_REQ = 2;
   localparam logic REQ0    = 1'b0;
   localparam logic REQ1    = 1'b1;

endpackage : adder_ctrl_pkg
`default_nettype wire

// File: rtl/adder_share_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : adder_share_arbiter_if                                   |
// | Purpose   : Two valid/ready request channels and one valid/ready     |
// |             response channel around the shared adder. "master" is   |
// |             the requester/consumer side, "slave" the arbiter side.   |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface adder_share_arbiter_if #(
   parameter int BIT_WIDTH = 8
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic [BIT_WIDTH-1:0] req0_a;
   logic [BIT_WIDTH-1:0] req0_b;
   logic                 req0_cin;

   logic                 req1_valid;
   logic                 req1_ready;
   logic [BIT_WIDTH-1:0] req1_a;
   logic [BIT_WIDTH-1:0] req1_b;
   logic                 req1_cin;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [BIT_WIDTH-1:0] rsp_sum;
   logic                 rsp_cout;
   logic                 rsp_id;

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_cin,
      input  req1_ready,
      input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_cin,
      output req1_ready,
      output rsp_valid, rsp_sum, rsp_cout, rsp_id,
      input  rsp_ready
   );

endinterface : adder_share_arbiter_if
`default_nettype wire

// File: rtl/adder_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : adder_nbit                                               |
// | Purpose   : Ripple-carry adder, {cout, sum} = a + b + cin.           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module adder_nbit #(
   parameter int BIT_WIDTH = 8
) (
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 cout
);

   logic [BIT_WIDTH:0] w_carry;

   assign w_carry[0] = cin;

   // One full adder per bit, carry rippling from LSB to MSB.
   for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
   end

   assign cout = w_carry[BIT_WIDTH];

endmodule : adder_nbit
`default_nettype wire

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : adder_share_arbiter                                      |
// | Purpose   : Time-shares one adder_nbit between two requesters using  |
// |             a round-robin grant and an IDLE/ADD/HOLD sequencer. The  |
// |             result is held on the response channel until consumed.   |
// | Options   : ADDER_SELF_CHECK_EN - compare the adder against a        |
// |             behavioural sum in ADD and raise a sticky err on mismatch|
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module adder_share_arbiter
   import adder_ctrl_pkg::*;
#(
   parameter int BIT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   adder_share_arbiter_if.slave  bus,
   output logic                  busy,
   output logic                  err
);

   state_t               r_state;
   state_t               w_next_state;

   logic [NUM_REQ-1:0]   w_valid;
   logic                 w_winner;
   logic                 w_accept;
   logic [BIT_WIDTH-1:0] w_sel_a;
   logic [BIT_WIDTH-1:0] w_sel_b;
   logic                 w_sel_cin;

   logic [BIT_WIDTH-1:0] r_op_a;
   logic [BIT_WIDTH-1:0] r_op_b;
   logic                 r_op_cin;
   logic                 r_id;
   logic                 r_last_grant;

   logic [BIT_WIDTH-1:0] w_add_sum;
   logic                 w_add_cout;

   logic                 r_rsp_valid;
   logic [BIT_WIDTH-1:0] r_rsp_sum;
   logic                 r_rsp_cout;
   logic                 r_rsp_id;

   assign w_valid = {bus.req1_valid, bus.req0_valid};

   // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      w_winner = REQ0;
      if (&w_valid) begin
         w_winner = ~r_last_grant;
      end else if (w_valid[1]) begin
         w_winner = REQ1;
      end
      w_sel_a   = (w_winner == REQ1) ? bus.req1_a   : bus.req0_a;
      w_sel_b   = (w_winner == REQ1) ? bus.req1_b   : bus.req0_b;
      w_sel_cin = (w_winner == REQ1) ? bus.req1_cin : bus.req0_cin;
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and request-side ready; ready only ever goes to a valid winner in IDLE.
   always_comb begin
      w_next_state   = r_state;
      w_accept       = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_valid) begin
               w_accept     = 1'b1;
               w_next_state = ADD;
               if (w_winner == REQ1) begin
                  bus.req1_ready = 1'b1;
               end else begin
                  bus.req0_ready = 1'b1;
               end
            end
         end
         ADD: begin
            w_next_state = HOLD;
         end
         HOLD: begin
            if (bus.rsp_ready) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Operand capture on grant, result capture in ADD, response release in HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_cin     <= 1'b0;
         r_id         <= REQ0;
         r_last_grant <= REQ1;
         r_rsp_valid  <= 1'b0;
         r_rsp_sum    <= '0;
         r_rsp_cout   <= 1'b0;
         r_rsp_id     <= REQ0;
      end else begin
         if (w_accept) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_op_cin     <= w_sel_cin;
            r_id         <= w_winner;
            r_last_grant <= w_winner;
         end
         if (r_state == ADD) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_add_sum;
            r_rsp_cout  <= w_add_cout;
            r_rsp_id    <= r_id;
         end else if ((r_state == HOLD) && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   adder_nbit #(
      .BIT_WIDTH (BIT_WIDTH)
   ) u_adder (
      .a    (r_op_a),
      .b    (r_op_b),
      .cin  (r_op_cin),
      .sum  (w_add_sum),
      .cout (w_add_cout)
   );

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_sum   = r_rsp_sum;
   assign bus.rsp_cout  = r_rsp_cout;
   assign bus.rsp_id    = r_rsp_id;
   assign busy          = (r_state == ADD) || (r_state == HOLD);

`ifdef ADDER_SELF_CHECK_EN
   logic [BIT_WIDTH:0] w_ref_sum;
   logic               r_err;

   assign w_ref_sum = {1'b0, r_op_a} + {1'b0, r_op_b} + {{BIT_WIDTH{1'b0}}, r_op_cin};

   // Sticky flag: any disagreement between the adder and the reference while adding.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if ((r_state == ADD) && ({w_add_cout, w_add_sum} != w_ref_sum)) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule : adder_share_arbiter
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_adder_share_arbiter                                   |
// | Purpose   : Self-checking bench for adder_share_arbiter. Expected    |
// |             responses are pushed to a scoreboard queue at grant time |
// |             and popped when the response channel presents a result. |
// | Options   : ADDER_SELF_CHECK_EN selects the err fault-injection test |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_adder_share_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic err;

   always #5 clk = ~clk;

   adder_share_arbiter_if #(.BIT_WIDTH(8)) bus ();

   adder_share_arbiter #(.BIT_WIDTH(8)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy),
      .err  (err)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [9:0] sb[$];
   bit         m_last;

   // Model: lone requester wins, tie goes to the one not granted last.
   function automatic bit model_winner(input bit v0, input bit v1, input bit last);
      if (v0 && v1) return ~last;
      return v1;
   endfunction

   // Model: {id, cout, sum} for a + b + cin.
   function automatic logic [9:0] model_rsp(input bit id, input logic [7:0] a,
                                            input logic [7:0] b, input bit cin);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      return {id, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit v0, input logic [7:0] a0, input logic [7:0] b0, input bit c0,
                          input bit v1, input logic [7:0] a1, input logic [7:0] b1, input bit c1);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_cin = c0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_cin = c1;
   endtask

   // Waits (bounded) for rsp_valid and captures the response; no checking here.
   task automatic collect(input int max, output bit ok, output logic [9:0] got, output int lat);
      ok  = 1'b0;
      lat = 0;
      got = '0;
      for (int i = 0; i < max; i++) begin
         if (bus.rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
         lat++;
      end
      if (bus.rsp_valid === 1'b1) ok = 1'b1;
      got = {bus.rsp_id, bus.rsp_cout, bus.rsp_sum};
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      bus.rsp_ready = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, busy, err} !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_state: got %h, expected %h",
                  {bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, busy, err}, 13'd0);
      end
      rst    = 1'b0;
      m_last = 1'b1;
      #1;
      n_cmp++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_no_ready: got %b, expected 00", {bus.req1_ready, bus.req0_ready});
      end
   endtask

   task automatic test_simultaneous();
      logic [9:0] exp, got;
      bit ok, w;
      int lat;
      set_req(1, 8'h3C, 8'h04, 0, 1, 8'h10, 8'h20, 1);
      #1;
      w = model_winner(1, 1, m_last);
      n_cmp++;
      if ({bus.req1_ready, bus.req0_ready} !== (w ? 2'b10 : 2'b01)) begin
         n_bad++;
         $display("FAIL tie_grant: got %b, expected %b", {bus.req1_ready, bus.req0_ready}, w ? 2'b10 : 2'b01);
      end
      sb.push_back(w ? model_rsp(1, 8'h10, 8'h20, 1) : model_rsp(0, 8'h3C, 8'h04, 0));
      m_last = w;
      tick();
      bus.req0_valid = 1'b0;
      #1;
      n_cmp++;
      if ({busy, bus.req1_ready, bus.req0_ready, bus.rsp_valid} !== 4'b1000) begin
         n_bad++;
         $display("FAIL add_phase: got %b, expected 1000",
                  {busy, bus.req1_ready, bus.req0_ready, bus.rsp_valid});
      end
      collect(4, ok, got, lat);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || lat != 1 || got !== exp) begin
         n_bad++;
         $display("FAIL first_rsp: got %h (valid=%0d lat=%0d), expected %h lat=1", got, ok, lat, exp);
      end
      release_rsp();
      #1;
      w = model_winner(0, 1, m_last);
      n_cmp++;
      if ({bus.rsp_valid, busy, bus.req1_ready, bus.req0_ready} !== {2'b00, w ? 2'b10 : 2'b01}) begin
         n_bad++;
         $display("FAIL second_grant: got %b, expected %b",
                  {bus.rsp_valid, busy, bus.req1_ready, bus.req0_ready}, {2'b00, w ? 2'b10 : 2'b01});
      end
      sb.push_back(model_rsp(w, 8'h10, 8'h20, 1));
      m_last = w;
      tick();
      bus.req1_valid = 1'b0;
      collect(4, ok, got, lat);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || got !== exp) begin
         n_bad++;
         $display("FAIL second_rsp: got %h (valid=%0d), expected %h", got, ok, exp);
      end
      release_rsp();
   endtask

   task automatic test_overflow();
      logic [9:0] exp, got;
      bit ok;
      int lat;
      set_req(0, 8'h00, 8'h00, 0, 1, 8'hFF, 8'h01, 0);
      #1;
      n_cmp++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         n_bad++;
         $display("FAIL ovf_grant: got %b, expected 10", {bus.req1_ready, bus.req0_ready});
      end
      sb.push_back(model_rsp(1, 8'hFF, 8'h01, 0));
      m_last = 1'b1;
      tick();
      bus.req1_valid = 1'b0;
      collect(4, ok, got, lat);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || lat != 1 || got !== exp) begin
         n_bad++;
         $display("FAIL ovf_rsp: got %h (valid=%0d lat=%0d), expected %h lat=1", got, ok, lat, exp);
      end
      release_rsp();
   endtask

   task automatic test_backpressure();
      logic [9:0] exp, got;
      bit ok;
      int lat;
      set_req(0, 8'h00, 8'h00, 0, 1, 8'hAA, 8'h55, 1);
      #1;
      n_cmp++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         n_bad++;
         $display("FAIL bp_grant: got %b, expected 10", {bus.req1_ready, bus.req0_ready});
      end
      sb.push_back(model_rsp(1, 8'hAA, 8'h55, 1));
      m_last = 1'b1;
      tick();
      bus.req1_valid = 1'b0;
      collect(4, ok, got, lat);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || got !== exp) begin
         n_bad++;
         $display("FAIL bp_rsp: got %h (valid=%0d), expected %h", got, ok, exp);
      end
      set_req(1, 8'h11, 8'h22, 0, 1, 8'h33, 8'h44, 1);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if ({bus.rsp_valid, busy, bus.req1_ready, bus.req0_ready} !== 4'b1100 ||
             {bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== exp) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got ctl=%b rsp=%h, expected ctl=1100 rsp=%h", i,
                     {bus.rsp_valid, busy, bus.req1_ready, bus.req0_ready},
                     {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, exp);
         end
         tick();
      end
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      release_rsp();
      n_cmp++;
      if ({bus.rsp_valid, busy} !== 2'b00 || {bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== exp) begin
         n_bad++;
         $display("FAIL bp_release: got ctl=%b rsp=%h, expected ctl=00 rsp=%h",
                  {bus.rsp_valid, busy}, {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, exp);
      end
   endtask

   task automatic test_fairness();
      logic [7:0] a0, b0, a1, b1;
      bit c0, c1, w;
      logic [9:0] exp, got;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom);
         a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
         set_req(1, a0, b0, c0, 1, a1, b1, c1);
         #1;
         w = model_winner(1, 1, m_last);
         n_cmp++;
         if ({bus.req1_ready, bus.req0_ready} !== (w ? 2'b10 : 2'b01) || w !== k[0]) begin
            n_bad++;
            $display("FAIL fair_grant[%0d]: got %b, expected %b", k,
                     {bus.req1_ready, bus.req0_ready}, k[0] ? 2'b10 : 2'b01);
         end
         sb.push_back(w ? model_rsp(1, a1, b1, c1) : model_rsp(0, a0, b0, c0));
         m_last = w;
         tick();
         tick();
         got = {bus.rsp_id, bus.rsp_cout, bus.rsp_sum};
         exp = sb.pop_front();
         n_cmp++;
         if (bus.rsp_valid !== 1'b1 || got !== exp) begin
            n_bad++;
            $display("FAIL fair_rsp[%0d]: got %h (valid=%b), expected %h", k, got, bus.rsp_valid, exp);
         end
         tick();
         n_cmp++;
         if ({bus.rsp_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_one_cycle[%0d]: got %b, expected 00", k, {bus.rsp_valid, busy});
         end
      end
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_drop_valid();
      logic [9:0] exp, got;
      bit ok, w;
      int lat;
      set_req(1, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0);
      #2;
      bus.req0_valid = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_no_grant: got busy=%b, expected 0", busy);
      end
      set_req(1, 8'h7F, 8'h01, 0, 1, 8'h80, 8'h80, 0);
      #1;
      w = model_winner(1, 1, m_last);
      n_cmp++;
      if ({bus.req1_ready, bus.req0_ready} !== (w ? 2'b10 : 2'b01)) begin
         n_bad++;
         $display("FAIL drop_last_kept: got %b, expected %b", {bus.req1_ready, bus.req0_ready}, w ? 2'b10 : 2'b01);
      end
      sb.push_back(w ? model_rsp(1, 8'h80, 8'h80, 0) : model_rsp(0, 8'h7F, 8'h01, 0));
      m_last = w;
      tick();
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      collect(4, ok, got, lat);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || got !== exp) begin
         n_bad++;
         $display("FAIL drop_rsp: got %h (valid=%0d), expected %h", got, ok, exp);
      end
      release_rsp();
   endtask

   task automatic test_reset_midop();
      logic [9:0] exp, got;
      bit ok, w;
      int lat;
      set_req(1, 8'h05, 8'h06, 0, 1, 8'h07, 8'h08, 1);
      tick();
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL hold_before_rst: got %b, expected 1", bus.rsp_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_last = 1'b1;
      n_cmp++;
      if ({bus.rsp_valid, busy, bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== 12'd0) begin
         n_bad++;
         $display("FAIL rst_in_hold: got %h, expected 000",
                  {bus.rsp_valid, busy, bus.rsp_sum, bus.rsp_cout, bus.rsp_id});
      end
      set_req(1, 8'h09, 8'h0A, 0, 0, 8'h00, 8'h00, 0);
      tick();
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({bus.rsp_valid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_in_add: got %b, expected 00", {bus.rsp_valid, busy});
      end
      set_req(1, 8'h21, 8'h12, 1, 1, 8'h99, 8'h01, 0);
      #1;
      w = model_winner(1, 1, m_last);
      n_cmp++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01 || w !== 1'b0) begin
         n_bad++;
         $display("FAIL post_rst_tie: got %b, expected 01", {bus.req1_ready, bus.req0_ready});
      end
      sb.push_back(model_rsp(0, 8'h21, 8'h12, 1));
      m_last = 1'b0;
      tick();
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      collect(4, ok, got, lat);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || got !== exp) begin
         n_bad++;
         $display("FAIL post_rst_rsp: got %h (valid=%0d), expected %h", got, ok, exp);
      end
      release_rsp();
   endtask

   task automatic test_err();
`ifdef ADDER_SELF_CHECK_EN
      set_req(1, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 0);
      tick();
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      force u_dut.w_add_sum = 8'h47;
      tick();
      release u_dut.w_add_sum;
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_set: got %b, expected 1", err);
      end
      release_rsp();
      tick();
      tick();
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: got %b, expected 1", err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_last = 1'b1;
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_cleared: got %b, expected 0", err);
      end
`else
      logic [9:0] exp, got;
      bit ok;
      int lat;
      set_req(1, 8'hFF, 8'hFF, 1, 0, 8'h00, 8'h00, 0);
      sb.push_back(model_rsp(0, 8'hFF, 8'hFF, 1));
      m_last = 1'b0;
      tick();
      set_req(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      collect(4, ok, got, lat);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || got !== exp || err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_off_rsp: got %h err=%b, expected %h err=0", got, err, exp);
      end
      release_rsp();
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_off: got %b, expected 0", err);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_overflow();
      test_backpressure();
      test_fairness();
      test_drop_valid();
      test_reset_midop();
      test_err();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_empty: got %0d entries, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_adder_share_arbiter
`default_nettype wire
